// File: rtl/ones_gen_pkg.sv
`default_nettype none
// ============================================================================
// ones_gen_pkg : shared state encoding and count-clamp helper for ones_generator
// Revision     : 1.0
// ============================================================================
package ones_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    function automatic int unsigned clamp_count(input int unsigned count,
                                                input int unsigned limit);
        return (count > limit) ? limit : count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ones_gen_ctrl.sv
`default_nettype none
// ============================================================================
// ones_gen_ctrl : IDLE/RUN/DONE sequencer steering the ones_generator datapath
// Revision      : 1.0
// ============================================================================
module ones_gen_ctrl
    import ones_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic remaining_zero,
    output logic load,
    output logic shift,
    output logic done_state
);

    state_e r_state;
    state_e w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // start is ignored in RUN: a run always completes once loaded
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)          w_next = RUN;
            RUN:     if (remaining_zero) w_next = DONE;
            DONE:    if (!start)         w_next = IDLE;
            default:                     w_next = IDLE;
        endcase
    end

    assign load       = (r_state == IDLE) && start;
    assign shift      = (r_state == RUN) && !remaining_zero;
    assign done_state = (r_state == DONE);

endmodule
`default_nettype wire

// File: rtl/ones_generator.sv
`default_nettype none
// ============================================================================
// ones_generator : shifts in a requested number of 1s at the LSB end of a word.
// Optional serial tap enabled by macro ONES_GEN_SERIAL_EN.   Revision : 1.0
// ============================================================================
module ones_generator
    import ones_gen_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] count_in,
    output logic [WIDTH-1:0]     pattern,
    output logic                 done,
    output logic                 sat
`ifdef ONES_GEN_SERIAL_EN
    ,
    output logic                 ser_out,
    output logic                 ser_valid
`endif
);

    if (CNT_WIDTH < $clog2(WIDTH + 1)) begin : g_bad_cnt_width
        $error("ones_generator: CNT_WIDTH too narrow to hold WIDTH");
    end

    logic [CNT_WIDTH-1:0] r_remaining;
    logic [CNT_WIDTH-1:0] w_clamped;
    logic                 w_over;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_done_state;

    assign w_clamped = CNT_WIDTH'(clamp_count(32'(count_in), WIDTH));
    assign w_over    = 32'(count_in) > WIDTH;

    ones_gen_ctrl u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .remaining_zero (r_remaining == '0),
        .load           (w_load),
        .shift          (w_shift),
        .done_state     (w_done_state)
    );

    // shift is only issued with remaining != 0, so the decrement cannot wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern     <= '0;
            sat         <= 1'b0;
            r_remaining <= '0;
        end else if (w_load) begin
            pattern     <= '0;
            sat         <= w_over;
            r_remaining <= w_clamped;
        end else if (w_shift) begin
            pattern     <= (pattern << 1) | WIDTH'(1);
            r_remaining <= r_remaining - CNT_WIDTH'(1);
        end
    end

    assign done = w_done_state;

`ifdef ONES_GEN_SERIAL_EN
    assign ser_out   = w_shift;
    assign ser_valid = w_shift;
`endif

endmodule
`default_nettype wire
